fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and decode.
// master = fetch_queue side, slave = memory/decode environment.
interface fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   inst_out;
    logic [31:0]   npc_out;
    logic          inst_valid;
    logic          inst_ready;
    logic [CW-1:0] queue_count;

    modport master (
        input  redirect, redirect_pc, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_out, npc_out, inst_valid, queue_count
    );

    modport slave (
        output redirect, redirect_pc, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_out, npc_out, inst_valid, queue_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Word-addressed instruction fetch queue: issues sequential fetches while there is
// room for the reply, buffers {inst, pc+1} pairs for decode, flushes on redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master fq
);
    localparam int            PW     = $clog2(DEPTH);
    localparam int            CW     = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_inst_mem [DEPTH];
    logic [31:0]   r_npc_mem  [DEPTH];

    logic [CW-1:0] w_occupied;
    logic          w_req;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;

    // Request gating counts the in-flight reply so a returning word always has a slot.
    always_comb begin
        w_occupied = r_count + (r_inflight ? ONE_C : {CW{1'b0}});
        w_req      = 1'b0;
        if (!rst && !fq.redirect && (w_occupied < FULL_C)) begin
            w_req = 1'b1;
        end else begin
            w_req = 1'b0;
        end
        w_valid = (r_count != {CW{1'b0}}) && !rst;
        w_push  = r_inflight && !fq.redirect;
        w_pop   = w_valid && fq.inst_ready && !fq.redirect;
    end

    assign fq.imem_req    = w_req;
    assign fq.imem_addr   = r_fetch_pc;
    assign fq.inst_valid  = w_valid;
    assign fq.inst_out    = w_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
    assign fq.npc_out     = w_valid ? r_npc_mem[r_rd_ptr]  : 32'h0;
    assign fq.queue_count = r_count;

    // Control state: fetch pc, in-flight tracking, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= 32'h0;
            r_inflight    <= 1'b0;
            r_wr_ptr      <= {PW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
            r_count       <= {CW{1'b0}};
        end else if (fq.redirect) begin
            r_fetch_pc <= fq.redirect_pc;
            r_inflight <= 1'b0;
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_fetch_pc    <= r_fetch_pc + 32'd1;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed through the gated head outputs.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_inst_mem[r_wr_ptr] <= fq.imem_rdata;
            r_npc_mem[r_wr_ptr]  <= r_inflight_pc + 32'd1;
        end
    end

    fetch_queue_chk #(.CW(CW)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_count (r_count),
        .i_full  (FULL_C)
    );
endmodule

// Occupancy guard: a push into a full queue means the request gating is broken.
module fetch_queue_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          i_push,
    input logic [CW-1:0] i_count,
    input logic [CW-1:0] i_full
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && (i_count == i_full)));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall, redirect, reset priority and pc wrap.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(4)) fa ();
    fetch_queue_if #(.DEPTH(4)) fb ();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk (clk),
        .rst (rst),
        .fq  (fa)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .fq  (fb)
    );

    // Instruction memory models: word k holds 0x1000 + k, one cycle latency.
    always @(posedge clk) begin
        if (fa.imem_req) fa.imem_rdata <= 32'h1000 + fa.imem_addr;
        if (fb.imem_req) fb.imem_rdata <= 32'h1000 + fb.imem_addr;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic ready);
        tick();
        rst            = 1'b1;
        fa.redirect    = 1'b0;
        fa.inst_ready  = ready;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_v;
        rst            = 1'b1;
        fa.redirect    = 1'b0;
        fa.redirect_pc = 32'h0;
        fa.inst_ready  = 1'b1;
        fb.redirect    = 1'b0;
        fb.redirect_pc = 32'h0;
        fb.inst_ready  = 1'b1;
        tick();
        tick();
        #1;
        check_val("rst_req",   32'(fa.imem_req),    32'h0);
        check_val("rst_valid", 32'(fa.inst_valid),  32'h0);
        check_val("rst_inst",  fa.inst_out,         32'h0);
        check_val("rst_npc",   fa.npc_out,          32'h0);
        check_val("rst_count", 32'(fa.queue_count), 32'h0);

        // Streaming after reset release, plus the wrapping instance.
        tick();
        rst = 1'b0;
        #1;
        check_val("s0_req",  32'(fa.imem_req), 32'h1);
        check_val("s0_addr", fa.imem_addr,     32'h0);
        check_val("w0_addr", fb.imem_addr,     32'hFFFF_FFFE);
        for (int c = 1; c < 8; c++) begin
            tick();
            #1;
            check_val("s_addr", fa.imem_addr, 32'(c));
            if (c >= 2) begin
                check_val("s_valid", 32'(fa.inst_valid), 32'h1);
                check_val("s_inst",  fa.inst_out, 32'h1000 + 32'(c - 2));
                check_val("s_npc",   fa.npc_out,  32'(c - 1));
            end else begin
                check_val("s_valid0", 32'(fa.inst_valid), 32'h0);
            end
            if (c <= 2) begin
                exp_v = 32'hFFFF_FFFE + 32'(c);
                check_val("w_addr", fb.imem_addr, exp_v);
            end
            if (c >= 2 && c <= 4) begin
                exp_v = 32'hFFFF_FFFE + 32'(c - 1);
                check_val("w_npc", fb.npc_out, exp_v);
            end
        end

        // Decode stall fills the queue, then drains without loss.
        restart(1'b0);
        for (int c = 1; c < 16; c++) begin
            tick();
            if (c == 10) fa.inst_ready = 1'b1;
            #1;
            if (c == 3) check_val("st_req3", 32'(fa.imem_req), 32'h1);
            if (c == 4) begin
                check_val("st_req4",   32'(fa.imem_req),    32'h0);
                check_val("st_count4", 32'(fa.queue_count), 32'h3);
            end
            if (c == 9) begin
                check_val("st_count9", 32'(fa.queue_count), 32'h4);
                check_val("st_req9",   32'(fa.imem_req),    32'h0);
            end
            if (c >= 2 && c < 10) check_val("st_hold", fa.inst_out, 32'h1000);
            if (c >= 10) begin
                check_val("dr_valid", 32'(fa.inst_valid), 32'h1);
                check_val("dr_inst",  fa.inst_out, 32'h1000 + 32'(c - 10));
            end
        end

        // Redirect with 3 queued + 1 in flight, then redirect over pop+push, then back-to-back.
        restart(1'b0);
        tick(); tick(); tick();
        tick();
        fa.redirect    = 1'b1;
        fa.redirect_pc = 32'h40;
        #1;
        check_val("rd_pre_cnt", 32'(fa.queue_count), 32'h3);
        check_val("rd_req",     32'(fa.imem_req),    32'h0);
        tick();
        fa.redirect   = 1'b0;
        fa.inst_ready = 1'b1;
        #1;
        check_val("rd1_count", 32'(fa.queue_count), 32'h0);
        check_val("rd1_valid", 32'(fa.inst_valid),  32'h0);
        check_val("rd1_addr",  fa.imem_addr,        32'h40);
        check_val("rd1_req",   32'(fa.imem_req),    32'h1);
        tick();
        #1;
        check_val("rd2_valid", 32'(fa.inst_valid), 32'h0);
        tick();
        #1;
        check_val("rd3_inst", fa.inst_out, 32'h1040);
        check_val("rd3_npc",  fa.npc_out,  32'h41);
        tick();
        fa.redirect    = 1'b1;
        fa.redirect_pc = 32'h80;
        #1;
        check_val("pp_head",  fa.inst_out,          32'h1041);
        check_val("pp_count", 32'(fa.queue_count),  32'h1);
        tick();
        fa.redirect_pc = 32'h90;
        #1;
        check_val("pp_count0", 32'(fa.queue_count), 32'h0);
        check_val("pp_valid0", 32'(fa.inst_valid),  32'h0);
        check_val("pp_addr",   fa.imem_addr,        32'h80);
        tick();
        fa.redirect = 1'b0;
        #1;
        check_val("bb_addr",  fa.imem_addr,     32'h90);
        check_val("bb_req",   32'(fa.imem_req), 32'h1);
        tick();
        #1;
        check_val("bb_valid", 32'(fa.inst_valid), 32'h0);
        tick();
        #1;
        check_val("bb_inst", fa.inst_out, 32'h1090);
        check_val("bb_npc",  fa.npc_out,  32'h91);

        // Reset beats redirect while the queue is full.
        restart(1'b0);
        for (int c = 1; c < 6; c++) tick();
        #1;
        check_val("rr_full", 32'(fa.queue_count), 32'h4);
        tick();
        rst            = 1'b1;
        fa.redirect    = 1'b1;
        fa.redirect_pc = 32'h200;
        #1;
        check_val("rr_req",   32'(fa.imem_req),   32'h0);
        check_val("rr_valid", 32'(fa.inst_valid), 32'h0);
        check_val("rr_inst",  fa.inst_out,        32'h0);
        tick();
        rst           = 1'b0;
        fa.redirect   = 1'b0;
        fa.inst_ready = 1'b1;
        #1;
        check_val("rr_count", 32'(fa.queue_count), 32'h0);
        check_val("rr_valid1", 32'(fa.inst_valid), 32'h0);
        check_val("rr_addr",  fa.imem_addr,        32'h0);
        check_val("rr_req1",  32'(fa.imem_req),    32'h1);
        tick();
        tick();
        #1;
        check_val("rr_inst2", fa.inst_out, 32'h1000);
        check_val("rr_npc2",  fa.npc_out,  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
